// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-computing pipeline: counter FSM states
// and default widths used by both the circuit stage and the stream counter.
package sc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WARM = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } sc_cnt_state_t;

  localparam int SC_CNT_W  = 16;
  localparam int SC_WARMUP = 2;

endpackage

// File: rtl/sc_stream_counter.sv
// Stochastic-to-binary converter: drops WARMUP valid bits after start, counts
// the 1s in the next stream_len valid bits, then holds the result until acked.
module sc_stream_counter
  import sc_pkg::*;
#(
  parameter int CNT_W  = SC_CNT_W,
  parameter int WARMUP = SC_WARMUP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] stream_len,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             busy,
  output logic             result_valid,
  output logic [CNT_W-1:0] ones,
  output logic [CNT_W-1:0] len_out,
  input  logic             result_ack
);

  localparam logic [CNT_W-1:0] WARM_LD = CNT_W'(WARMUP);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  sc_cnt_state_t    state, state_n;
  logic [CNT_W-1:0] cnt;      // bits still to take in the current phase
  logic [CNT_W-1:0] acc;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] ones_q;
  logic [CNT_W-1:0] acc_inc;
  logic             last;

  assign acc_inc = acc + {{(CNT_W-1){1'b0}}, in_bit};
  assign last    = in_valid && (cnt == ONE);

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (stream_len == '0)  state_n = DONE;
          else if (WARMUP == 0)  state_n = RUN;
          else                   state_n = WARM;
        end
      end
      WARM: if (last) state_n = RUN;
      RUN:  if (last) state_n = DONE;
      DONE: if (result_ack) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // One down-counter serves both phases; it is reloaded with the length at WARM->RUN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt          <= '0;
      acc          <= '0;
      len_q        <= '0;
      ones_q       <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      busy         <= (state_n == WARM) || (state_n == RUN);
      result_valid <= (state_n == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            len_q  <= stream_len;
            acc    <= '0;
            ones_q <= '0;
            cnt    <= (WARMUP == 0) ? stream_len : WARM_LD;
          end
        end
        WARM: begin
          if (in_valid) cnt <= last ? len_q : cnt - ONE;
        end
        RUN: begin
          if (in_valid) begin
            acc <= acc_inc;
            cnt <= cnt - ONE;
            if (last) ones_q <= acc_inc;
          end
        end
        default: ;
      endcase
    end
  end

  assign ones    = ones_q;
  assign len_out = len_q;

endmodule

// File: tb/tb_sc_stream_counter.sv
// Randomized bench for sc_stream_counter: a queue of accepted bits is the
// reference; ones = sum of the bits after the first WARMUP valid ones.
module tb_sc_stream_counter;

  localparam int W  = 2;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] stream_len;
  logic          in_bit;
  logic          in_valid;
  logic          busy;
  logic          result_valid;
  logic [CW-1:0] ones;
  logic [CW-1:0] len_out;
  logic          result_ack;

  int errs = 0;
  int checks = 0;

  sc_stream_counter #(.CNT_W(CW), .WARMUP(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stream_len(stream_len),
    .in_bit(in_bit), .in_valid(in_valid), .busy(busy),
    .result_valid(result_valid), .ones(ones), .len_out(len_out),
    .result_ack(result_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One full measurement: launch, feed bits, check timing each cycle, check result, handshake.
  task automatic measure(input int L, input int vpct, input int opct, input bit use_pat,
                         input logic [31:0] vpat, input logic [31:0] bpat,
                         input bit poke_start, input int ack_hold, input bit ack_start);
    int q[$];
    int nv, it, exp_ones;
    logic v, b;
    @(negedge clk);
    start = 1'b1; stream_len = L[CW-1:0]; in_valid = 1'b0; in_bit = 1'b0; result_ack = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_e0", busy, L != 0);
    chk("rv_e0", result_valid, L == 0);
    nv = 0; it = 0;
    if (L != 0) begin
      while (nv < W + L) begin
        @(negedge clk);
        if (use_pat) begin
          v = vpat[it % 32]; b = bpat[nv % 32];
        end else begin
          v = ($urandom_range(99) < vpct);
          b = ($urandom_range(99) < opct);
        end
        if (it > 4 * (W + L) + 40) v = 1'b1;
        in_valid = v; in_bit = b;
        start = poke_start && ($urandom_range(3) == 0);
        stream_len = CW'($urandom);
        @(posedge clk); #1;
        if (v) begin q.push_back(int'(b)); nv++; end
        it++;
        chk("busy", busy, nv < W + L);
        chk("rv", result_valid, nv >= W + L);
      end
    end
    exp_ones = 0;
    for (int i = W; i < W + L; i++) exp_ones += q[i];
    chk("ones", ones, exp_ones);
    chk("len_out", len_out, L);
    for (int k = 0; k < ack_hold; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_bit = 1'($urandom); start = 1'($urandom);
      @(posedge clk); #1;
      chk("hold_rv", result_valid, 1);
      chk("hold_ones", ones, exp_ones);
      chk("hold_len", len_out, L);
    end
    @(negedge clk);
    in_valid = 1'b0; result_ack = 1'b1; start = ack_start;
    @(posedge clk); #1;
    chk("ack_rv", result_valid, 0);
    chk("ack_busy", busy, 0);
    @(negedge clk);
    result_ack = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy", busy, 0);
    chk("idle_rv", result_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stream_len = '0; in_bit = 1'b0;
    in_valid = 1'b0; result_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_ones", ones, 0);
    chk("rst_len", len_out, 0);
    @(negedge clk) rst_n = 1'b1;

    // basic: continuous valid, stream 1,1 | 1,0,1,1,0,0,1,1
    measure(8, 100, 0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0337, 1'b0, 5, 1'b1);
    // gapped valid, all ones
    measure(4, 100, 0, 1'b1, 32'hFFFF_FFCD, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
    // zero-length start
    measure(0, 100, 0, 1'b0, '0, '0, 1'b0, 2, 1'b1);
    // start pulsed during WARM/RUN
    measure(12, 70, 50, 1'b0, '0, '0, 1'b1, 1, 1'b1);
    // randomized lengths, valid densities and bit probabilities
    for (int r = 0; r < 20; r++)
      measure($urandom_range(1, 40), $urandom_range(30, 100), $urandom_range(0, 100),
              1'b0, '0, '0, r[0], $urandom_range(0, 3), 1'($urandom));
    // all-zeros stream
    measure(1000, 100, 0, 1'b0, '0, '0, 1'b0, 0, 1'b0);

    // reset mid-RUN after 3 counted bits
    @(negedge clk);
    start = 1'b1; stream_len = 16'd8; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_bit = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_rv", result_valid, 0);
    chk("mrst_ones", ones, 0);
    chk("mrst_len", len_out, 0);
    @(negedge clk) rst_n = 1'b1;
    measure(8, 100, 50, 1'b0, '0, '0, 1'b0, 0, 1'b0);

    // full-scale length, all ones
    measure(65535, 100, 100, 1'b0, '0, '0, 1'b0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
